// File: rtl/branch_stat_counter.sv
// Retired-branch / taken-branch counters for the two retire lanes, published
// as periodic snapshots so the downstream seven-segment display stays stable.
module branch_stat_counter #(
    parameter int unsigned WIDTH       = 32,
    parameter logic [31:0] SNAP_PERIOD = 32'd1000000,
    parameter bit          SATURATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [1:0]       i_br_valid,
    input  logic [1:0]       i_br_taken,
    input  logic             i_en,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_branches_counter,
    output logic [WIDTH-1:0] o_branches_taken_counter,
    output logic             o_snap_stb,
    output logic             o_ovf
);

    localparam int unsigned TW = $clog2(SNAP_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SNAP_PERIOD - 32'd1);

    logic [WIDTH-1:0] cnt_all, cnt_tkn;
    logic [WIDTH-1:0] nxt_all, nxt_tkn;
    logic             nxt_ovf;
    logic [1:0]       inc_all, inc_tkn;
    logic [1:0]       tkn_lanes;
    logic [WIDTH:0]   sum_all, sum_tkn;
    logic [TW-1:0]    timer;

    always_comb begin
        tkn_lanes = i_br_valid & i_br_taken;
        inc_all   = {1'b0, i_br_valid[0]} + {1'b0, i_br_valid[1]};
        inc_tkn   = {1'b0, tkn_lanes[0]} + {1'b0, tkn_lanes[1]};
        sum_all   = {1'b0, cnt_all} + {{(WIDTH-1){1'b0}}, inc_all};
        sum_tkn   = {1'b0, cnt_tkn} + {{(WIDTH-1){1'b0}}, inc_tkn};
    end

    // A carry-out only occurs with a non-zero increment, so an all-ones counter
    // seeing no events neither moves nor flags overflow.
    always_comb begin
        nxt_all = cnt_all;
        nxt_tkn = cnt_tkn;
        nxt_ovf = o_ovf;
        if (i_en) begin
            nxt_all = (SATURATE && sum_all[WIDTH]) ? '1 : sum_all[WIDTH-1:0];
            nxt_tkn = (SATURATE && sum_tkn[WIDTH]) ? '1 : sum_tkn[WIDTH-1:0];
            nxt_ovf = o_ovf | sum_all[WIDTH] | sum_tkn[WIDTH];
        end
    end

    // Snapshots load the next-state values so events in the load cycle are shown.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_all                  <= '0;
            cnt_tkn                  <= '0;
            o_ovf                    <= 1'b0;
            timer                    <= '0;
            o_branches_counter       <= '0;
            o_branches_taken_counter <= '0;
            o_snap_stb               <= 1'b0;
        end else if (i_clear) begin
            cnt_all                  <= '0;
            cnt_tkn                  <= '0;
            o_ovf                    <= 1'b0;
            timer                    <= '0;
            o_branches_counter       <= '0;
            o_branches_taken_counter <= '0;
            o_snap_stb               <= 1'b0;
        end else begin
            cnt_all <= nxt_all;
            cnt_tkn <= nxt_tkn;
            o_ovf   <= nxt_ovf;
            if (timer == TIMER_LAST) begin
                timer                    <= '0;
                o_branches_counter       <= nxt_all;
                o_branches_taken_counter <= nxt_tkn;
                o_snap_stb               <= 1'b1;
            end else begin
                timer      <= timer + TW'(1);
                o_snap_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_stat_counter.sv
// Directed bench for branch_stat_counter: one 32-bit saturating instance plus
// 8-bit saturating and wrapping instances sharing stimulus.
module tb_branch_stat_counter;

    localparam int PI = 16;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic [1:0]  m_valid, m_taken;
    logic        m_en, m_clear;
    logic [31:0] m_all, m_tkn;
    logic        m_stb, m_ovf;

    logic [1:0]  s_valid, s_taken;
    logic        s_en, s_clear;
    logic [7:0]  sa_all, sa_tkn, wa_all, wa_tkn;
    logic        sa_stb, sa_ovf, wa_stb, wa_ovf;

    branch_stat_counter #(.WIDTH(32), .SNAP_PERIOD(32'd16), .SATURATE(1'b1)) u_main (
        .clk(clk), .rstn(rstn), .i_br_valid(m_valid), .i_br_taken(m_taken),
        .i_en(m_en), .i_clear(m_clear), .o_branches_counter(m_all),
        .o_branches_taken_counter(m_tkn), .o_snap_stb(m_stb), .o_ovf(m_ovf));

    branch_stat_counter #(.WIDTH(8), .SNAP_PERIOD(32'd16), .SATURATE(1'b1)) u_sat8 (
        .clk(clk), .rstn(rstn), .i_br_valid(s_valid), .i_br_taken(s_taken),
        .i_en(s_en), .i_clear(s_clear), .o_branches_counter(sa_all),
        .o_branches_taken_counter(sa_tkn), .o_snap_stb(sa_stb), .o_ovf(sa_ovf));

    branch_stat_counter #(.WIDTH(8), .SNAP_PERIOD(32'd16), .SATURATE(1'b0)) u_wrap8 (
        .clk(clk), .rstn(rstn), .i_br_valid(s_valid), .i_br_taken(s_taken),
        .i_en(s_en), .i_clear(s_clear), .o_branches_counter(wa_all),
        .o_branches_taken_counter(wa_tkn), .o_snap_stb(wa_stb), .o_ovf(wa_ovf));

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [1:0]  v1, t1;
        int          n1;
        logic [1:0]  v2, t2;
        int          n2;
        logic        en;
        logic [31:0] exp_all, exp_tkn;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until the selected strobe is seen; k = cycles waited.
    task automatic wait_stb(input bit sel, output int k);
        k = 0;
        while (k < 3 * PI) begin
            step();
            k++;
            if ((sel ? sa_stb : m_stb) === 1'b1) return;
        end
        tests++;
        failed++;
        $display("FAIL strobe_timeout: got no strobe, expected one within %0d cycles", 3 * PI);
    endtask

    initial begin
        int k;
        int stb_at;
        int pulses;
        int bad;

        //            v1     t1     n1  v2     t2     n2  en    all   tkn
        vecs[0] = '{2'b11, 2'b01, 5,  2'b10, 2'b10, 3, 1'b1, 32'd13, 32'd8};
        vecs[1] = '{2'b00, 2'b11, 10, 2'b00, 2'b00, 0, 1'b1, 32'd13, 32'd8};
        vecs[2] = '{2'b01, 2'b00, 15, 2'b00, 2'b00, 0, 1'b0, 32'd13, 32'd8};
        vecs[3] = '{2'b01, 2'b01, 7,  2'b10, 2'b00, 4, 1'b1, 32'd24, 32'd15};
        vecs[4] = '{2'b11, 2'b11, 15, 2'b00, 2'b00, 0, 1'b1, 32'd54, 32'd45};
        vecs[5] = '{2'b10, 2'b01, 6,  2'b01, 2'b10, 2, 1'b1, 32'd62, 32'd45};

        rstn = 1'b0;
        m_valid = '0; m_taken = '0; m_en = 1'b1; m_clear = 1'b0;
        s_valid = '0; s_taken = '0; s_en = 1'b1; s_clear = 1'b0;

        step();
        check("reset_all", m_all, 0);
        check("reset_tkn", m_tkn, 0);
        check("reset_stb", {31'd0, m_stb}, 0);
        check("reset_ovf", {31'd0, m_ovf}, 0);
        #2 rstn = 1'b1;

        wait_stb(1'b0, k);
        check("first_snap_delay", k, PI);
        check("first_snap_all", m_all, 0);

        for (int r = 0; r < 6; r++) begin
            m_en = vecs[r].en;
            for (int i = 0; i < vecs[r].n1; i++) begin
                m_valid = vecs[r].v1; m_taken = vecs[r].t1; step();
            end
            for (int i = 0; i < vecs[r].n2; i++) begin
                m_valid = vecs[r].v2; m_taken = vecs[r].t2; step();
            end
            m_valid = '0; m_taken = '0; m_en = 1'b1;
            wait_stb(1'b0, k);
            check($sformatf("row%0d_period", r), vecs[r].n1 + vecs[r].n2 + k, PI);
            check($sformatf("row%0d_all", r), m_all, vecs[r].exp_all);
            check($sformatf("row%0d_tkn", r), m_tkn, vecs[r].exp_tkn);
            check($sformatf("row%0d_ovf", r), {31'd0, m_ovf}, 0);
        end

        // Freeze across a snapshot boundary, then resume.
        stb_at = -1;
        m_en = 1'b0; m_valid = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (m_stb === 1'b1) stb_at = i;
        end
        check("freeze_stb_at", stb_at, PI);
        check("freeze_all", m_all, 62);
        check("freeze_tkn", m_tkn, 45);
        m_en = 1'b1;
        repeat (3) step();
        m_valid = '0;
        wait_stb(1'b0, k);
        check("resume_period", 23 + k, 2 * PI);
        check("resume_all", m_all, 65);
        check("resume_tkn", m_tkn, 45);

        // Clear colliding with events, mid-period.
        repeat (5) step();
        m_clear = 1'b1; m_valid = 2'b11; m_taken = 2'b11;
        step();
        m_clear = 1'b0; m_valid = '0; m_taken = '0;
        check("clear_all_now", m_all, 0);
        check("clear_tkn_now", m_tkn, 0);
        check("clear_stb_now", {31'd0, m_stb}, 0);
        wait_stb(1'b0, k);
        check("clear_restart", k, PI);
        check("clear_snap_all", m_all, 0);
        check("clear_snap_tkn", m_tkn, 0);

        m_valid = 2'b11; m_taken = 2'b10;
        repeat (3) step();
        m_valid = '0; m_taken = '0;
        wait_stb(1'b0, k);
        check("post_clear_all", m_all, 6);
        check("post_clear_tkn", m_tkn, 3);

        // 8-bit saturate vs wrap.
        s_clear = 1'b1; step(); s_clear = 1'b0;
        s_valid = 2'b11;
        repeat (127) step();
        s_valid = '0;
        wait_stb(1'b1, k);
        check("sat_254", sa_all, 254);
        check("wrap_254", wa_all, 254);
        check("sat_254_ovf", {31'd0, sa_ovf}, 0);
        check("wrap_254_ovf", {31'd0, wa_ovf}, 0);
        s_valid = 2'b11; step(); s_valid = '0;
        wait_stb(1'b1, k);
        check("sat_top", sa_all, 255);
        check("sat_top_ovf", {31'd0, sa_ovf}, 1);
        check("wrap_top", wa_all, 0);
        check("wrap_top_ovf", {31'd0, wa_ovf}, 1);
        check("sat_tkn_zero", sa_tkn, 0);
        s_valid = 2'b11; step(); s_valid = '0;
        wait_stb(1'b1, k);
        check("sat_stick", sa_all, 255);
        check("wrap_after", wa_all, 2);
        check("wrap_ovf_sticky", {31'd0, wa_ovf}, 1);

        s_clear = 1'b1; s_valid = 2'b11; s_taken = 2'b11;
        step();
        s_clear = 1'b0; s_valid = '0; s_taken = '0;
        check("sclear_sat_ovf", {31'd0, sa_ovf}, 0);
        check("sclear_wrap_ovf", {31'd0, wa_ovf}, 0);
        wait_stb(1'b1, k);
        check("sclear_restart", k, PI);
        check("sclear_sat_all", sa_all, 0);
        check("sclear_sat_tkn", sa_tkn, 0);
        check("sclear_wrap_all", wa_all, 0);

        // Asynchronous reset mid-cycle, right after a snapshot strobe.
        wait_stb(1'b0, k);
        #2 rstn = 1'b0;
        #1;
        check("async_all", m_all, 0);
        check("async_tkn", m_tkn, 0);
        check("async_stb", {31'd0, m_stb}, 0);
        step();
        #2 rstn = 1'b1;
        pulses = 0; bad = 0; stb_at = -1;
        for (int i = 1; i <= 2 * PI; i++) begin
            step();
            if (m_stb === 1'b1) begin
                pulses++;
                if (stb_at < 0) stb_at = i;
            end
            if (m_all !== 32'd0 || m_tkn !== 32'd0 || m_ovf !== 1'b0) bad++;
        end
        check("idle_pulses", pulses, 2);
        check("idle_first_pulse", stb_at, PI);
        check("idle_nonzero_cycles", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
